// File: rtl/popcount_pattern_gen_if.sv
// Request/response bundle for popcount_pattern_gen: count/mode in, generated word out.
// master = requester/consumer side, slave = the pattern generator.
interface popcount_pattern_gen_if #(
    parameter int WIDTH = 64,
    parameter int CW    = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_count;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [CW-1:0]    out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_count, in_mode, out_ready,
        input  in_ready, out_valid, out_word, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_count, in_mode, out_ready,
        output in_ready, out_valid, out_word, out_count, out_sat
    );
endinterface

// File: rtl/popcount_pattern_gen.sv
// Builds a WIDTH-bit word with exactly min(in_count,WIDTH) ones, thermometer or Bresenham spread, LANES bits/cycle.
// out_valid rises WIDTH/LANES edges after accept; word held until out_ready, in_ready low throughout.
module popcount_pattern_gen #(
    parameter int WIDTH = 64,
    parameter int LANES = 8,
    parameter int CW    = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    popcount_pattern_gen_if.slave bus
);
    localparam int NL = WIDTH / LANES;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [CW-1:0] WIDTH_C   = CW'(WIDTH);
    localparam logic [LW-1:0] LAST_LANE = LW'(NL - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUILD, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;
    logic             mode_q, mode_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [CW-1:0]    acc_q, acc_d;

    logic [LANES-1:0] lane_bits;
    logic [CW-1:0]    acc_c;
    logic [CW-1:0]    sum_c;

    // One lane of output bits; in spread mode the accumulator steps chain through all LANES bits.
    always_comb begin
        lane_bits = '0;
        acc_c     = acc_q;
        sum_c     = '0;
        for (int j = 0; j < LANES; j++) begin
            if (mode_q) begin
                sum_c = acc_c + out_count_q;
                if (sum_c >= WIDTH_C) begin
                    lane_bits[j] = 1'b1;
                    acc_c        = sum_c - WIDTH_C;
                end else begin
                    acc_c = sum_c;
                end
            end else begin
                lane_bits[j] = (int'(lane_q) * LANES + j) < int'(out_count_q);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        mode_d      = mode_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    out_sat_d   = bus.in_count > WIDTH_C;
                    out_count_d = (bus.in_count > WIDTH_C) ? WIDTH_C : bus.in_count;
                    mode_d      = bus.in_mode;
                    out_word_d  = '0;
                    lane_d      = '0;
                    acc_d       = '0;
                    state_d     = S_BUILD;
                end
            end
            S_BUILD: begin
                out_word_d = out_word_q | (WIDTH'(lane_bits) << (int'(lane_q) * LANES));
                acc_d      = acc_c;
                lane_d     = lane_q + LW'(1);
                if (lane_q == LAST_LANE) begin
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered ready: low on the reset edge, and low for the edge that leaves HOLD.
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            mode_q      <= 1'b0;
            lane_q      <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            mode_q      <= mode_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
endmodule
